// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write port.
// One request is granted per cycle with a combinational ready. The winner's
// address and data are registered into a single write stage (latency 1).
// Writes to address 0 are accepted but suppressed. pendingK flags when a
// read address hits the staged write, so readers can forward fwdData.
// Optional feature: define RF_WRITE_ARB_RR_EN for round-robin contention
// handling. Without it, requester 0 always has priority.
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0Valid,
  input  logic [ADR_W-1:0]  req0Adr,
  input  logic [DATA_W-1:0] req0Data,
  input  logic              req1Valid,
  input  logic [ADR_W-1:0]  req1Adr,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req0Ready,
  output logic              req1Ready,
  output logic              regWrite,
  output logic [ADR_W-1:0]  writeAdr,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADR_W-1:0]  queryAdr1,
  input  logic [ADR_W-1:0]  queryAdr2,
  output logic              pending1,
  output logic              pending2,
  output logic [DATA_W-1:0] fwdData
);

  logic              prefer0;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADR_W-1:0]  selAdr;
  logic [DATA_W-1:0] selData;

`ifdef RF_WRITE_ARB_RR_EN
  // 1 means requester 1 won the most recent transfer, so requester 0 is
  // favoured next. Resetting to 1 makes requester 0 win first contention.
  logic lastGrant;

  // Remember which requester won the latest transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      lastGrant <= 1'b1;
    else if (xfer) lastGrant <= grant1;
  end

  assign prefer0 = lastGrant;
`else
  assign prefer0 = 1'b1;
`endif

  // Grants depend only on the valids and the arbitration state, never on
  // the requesters' address or data. Both are held low while in reset.
  assign grant0    = rst & req0Valid & (~req1Valid | prefer0);
  assign grant1    = rst & req1Valid & ~(req0Valid & prefer0);
  assign req0Ready = grant0;
  assign req1Ready = grant1;
  assign xfer      = grant0 | grant1;
  assign selAdr    = grant1 ? req1Adr  : req0Adr;
  assign selData   = grant1 ? req1Data : req0Data;

  // Write stage: capture the winner; address 0 is accepted but not written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite  <= 1'b0;
      writeAdr  <= '0;
      writeData <= '0;
    end else if (xfer) begin
      regWrite  <= (selAdr != '0);
      writeAdr  <= selAdr;
      writeData <= selData;
    end else begin
      regWrite  <= 1'b0;
    end
  end

  assign pending1 = regWrite & (writeAdr == queryAdr1) & (writeAdr != '0);
  assign pending2 = regWrite & (writeAdr == queryAdr2) & (writeAdr != '0);
  assign fwdData  = writeData;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a transaction model.
module tb_rf_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADR_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0Valid = 1'b0, req1Valid = 1'b0;
  logic [ADR_W-1:0]  req0Adr = '0, req1Adr = '0;
  logic [DATA_W-1:0] req0Data = '0, req1Data = '0;
  logic              req0Ready, req1Ready, regWrite, pending1, pending2;
  logic [ADR_W-1:0]  writeAdr;
  logic [DATA_W-1:0] writeData, fwdData;
  logic [ADR_W-1:0]  queryAdr1 = '0, queryAdr2 = '0;

  int checks = 0;
  int failures = 0;

  rf_write_arbiter #(.DATA_W(DATA_W), .ADR_W(ADR_W)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req0Adr(req0Adr), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Adr(req1Adr), .req1Data(req1Data),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .regWrite(regWrite), .writeAdr(writeAdr), .writeData(writeData),
    .queryAdr1(queryAdr1), .queryAdr2(queryAdr2),
    .pending1(pending1), .pending2(pending2), .fwdData(fwdData)
  );

  always #5 clk = ~clk;

  // ---- transaction-level model ----
  // mLast: index of the requester that won the latest transfer (1 after reset)
  int                mLast = 1;
  bit                mWr = 0;
  logic [ADR_W-1:0]  mAdr = '0;
  logic [DATA_W-1:0] mData = '0;
  bit                x0 = 0, x1 = 0;

  // Who wins this cycle: -1 nobody, else the requester index.
  function automatic int winner(bit v0, bit v1, int last);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!v0 && !v1) return -1;
`ifdef RF_WRITE_ARB_RR_EN
    return (last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mWr = 0; mAdr = '0; mData = '0; mLast = 1; x0 = 0; x1 = 0;
    end else begin
      int w;
      w  = winner(req0Valid, req1Valid, mLast);
      x0 = (w == 0);
      x1 = (w == 1);
      if (w >= 0) begin
        mAdr  = (w == 0) ? req0Adr  : req1Adr;
        mData = (w == 0) ? req0Data : req1Data;
        mWr   = (mAdr != 0);
        mLast = w;
      end else begin
        mWr = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model.
  task automatic checkOuts();
    int w;
    w = rst ? winner(req0Valid, req1Valid, mLast) : -1;
    chk("req0Ready", req0Ready, w == 0);
    chk("req1Ready", req1Ready, w == 1);
    chk("regWrite", regWrite, mWr);
    chk("writeAdr", writeAdr, mAdr);
    chk("writeData", writeData, mData);
    chk("fwdData", fwdData, mData);
    chk("pending1", pending1, mWr && mAdr == queryAdr1 && mAdr != 0);
    chk("pending2", pending2, mWr && mAdr == queryAdr2 && mAdr != 0);
  endtask

  // One cycle: check settled outputs, drive new inputs, check again.
  task automatic cycle(input bit v0, input int a0, input int d0,
                       input bit v1, input int a1, input int d1,
                       input int q1, input int q2);
    @(negedge clk);
    checkOuts();
    req0Valid = v0; req0Adr = a0[ADR_W-1:0]; req0Data = d0;
    req1Valid = v1; req1Adr = a1[ADR_W-1:0]; req1Data = d1;
    queryAdr1 = q1[ADR_W-1:0]; queryAdr2 = q2[ADR_W-1:0];
    #1 checkOuts();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 0;
    req0Valid = 1; req0Adr = 3; req0Data = 32'h1234;
    req1Valid = 1; req1Adr = 4; req1Data = 32'h5678;
    queryAdr1 = 3; queryAdr2 = 4;
    #1;
    chk("rst_req0Ready", req0Ready, 0);
    chk("rst_req1Ready", req1Ready, 0);
    @(negedge clk);
    chk("rst_regWrite", regWrite, 0);
    chk("rst_writeAdr", writeAdr, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_pending1", pending1, 0);
    chk("rst_pending2", pending2, 0);
    req0Valid = 0; req1Valid = 0;
    rst = 1;
  endtask

  bit p0v, p1v;
  int p0a, p0d, p1a, p1d;
  bit expG0 [4];

  initial begin
    // Reset, then a single write to r3.
    doReset();
    cycle(1, 3, 'hA5, 0, 0, 0, 3, 0);
    chk("s030_req0Ready", req0Ready, 1);
    chk("s030_req1Ready", req1Ready, 0);
    cycle(0, 0, 0, 1, 0, 'hFF, 3, 0);
    chk("s030_regWrite", regWrite, 1);
    chk("s030_writeAdr", writeAdr, 3);
    chk("s030_writeData", writeData, 'hA5);
    chk("s030_pending1", pending1, 1);
    // Same cycle: requester 1 writes r0 -> accepted but suppressed.
    chk("s031_req1Ready", req1Ready, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s031_regWrite", regWrite, 0);
    chk("s031_pending1", pending1, 0);
    chk("s031_pending2", pending2, 0);

    // Contention for 4 cycles, fresh reset.
    doReset();
`ifdef RF_WRITE_ARB_RR_EN
    expG0 = '{1, 0, 1, 0};
`else
    expG0 = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(1, 4, 'h40 + i, 1, 5, 'h55, 4, 5);
      chk("s032_req0Ready", req0Ready, expG0[i]);
      chk("s032_req1Ready", req1Ready, !expG0[i]);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Same-address contention: 0x11 then 0x22 on consecutive cycles.
    doReset();
    cycle(1, 7, 'h11, 1, 7, 'h22, 7, 7);
    chk("s033_req0Ready", req0Ready, 1);
    cycle(0, 0, 0, 1, 7, 'h22, 7, 7);
    chk("s033_first_wr", regWrite, 1);
    chk("s033_first_data", writeData, 'h11);
    chk("s033_req1Ready", req1Ready, 1);
    cycle(0, 0, 0, 0, 0, 0, 7, 7);
    chk("s033_second_wr", regWrite, 1);
    chk("s033_second_adr", writeAdr, 7);
    chk("s033_second_data", writeData, 'h22);

    // Back-to-back writes r1, r2, r3.
    cycle(1, 1, 'h101, 0, 0, 0, 1, 0);
    cycle(1, 2, 'h102, 0, 0, 0, 1, 0);
    chk("s035_wr1", regWrite, 1);
    chk("s035_adr1", writeAdr, 1);
    cycle(1, 3, 'h103, 0, 0, 0, 1, 0);
    chk("s035_wr2", regWrite, 1);
    chk("s035_adr2", writeAdr, 2);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    chk("s035_wr3", regWrite, 1);
    chk("s035_adr3", writeAdr, 3);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s035_idle", regWrite, 0);

    // Reset mid-stream drops the staged write immediately.
    cycle(1, 2, 'h77, 0, 0, 0, 2, 0);
    cycle(1, 2, 'h78, 0, 0, 0, 2, 0);
    chk("s034_pre_wr", regWrite, 1);
    #2 rst = 0;
    #1;
    chk("s034_wr_drop", regWrite, 0);
    chk("s034_ready_low", req0Ready, 0);
    chk("s034_pend_low", pending1, 0);
    repeat (2) begin
      @(negedge clk);
      chk("s034_hold_ready", req0Ready, 0);
      chk("s034_hold_wr", regWrite, 0);
    end
    rst = 1;
    #1 chk("s034_release_ready", req0Ready, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("s034_post_wr", regWrite, 1);
    chk("s034_post_data", writeData, 'h78);

    // Randomized traffic; a requester holds its request until accepted.
    p0v = 0; p1v = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checkOuts();
      if (x0) p0v = 0;
      if (x1) p1v = 0;
      if (!p0v && $urandom_range(0, 99) < 65) begin
        p0v = 1; p0a = $urandom_range(0, 7); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 99) < 65) begin
        p1v = 1; p1a = $urandom_range(0, 7); p1d = $urandom;
      end
      req0Valid = p0v; req0Adr = p0a[ADR_W-1:0]; req0Data = p0d;
      req1Valid = p1v; req1Adr = p1a[ADR_W-1:0]; req1Data = p1d;
      queryAdr1 = $urandom_range(0, 7);
      queryAdr2 = $urandom_range(0, 7);
      #1 checkOuts();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
